// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: state encoding and default operand width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference when it is non-negative, otherwise restore.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dividendBit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             quotBit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor, so the shifted value fits in
  // WIDTH+1 bits and a non-negative difference always fits back into WIDTH bits.
  always_comb begin
    shifted   = {rem_i, dividendBit_i};
    diff      = shifted - {1'b0, divisor_i};
    quotBit_o = ~diff[WIDTH];
    rem_o     = quotBit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: one quotient bit per cycle, sign fix-up on
// completion, quotient to LO and remainder to HI, stall request while working.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_div_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             negQuot_q, negQuot_d;
  logic             negRem_q, negRem_d;

  logic             accept;
  logic [WIDTH-1:0] aMag;
  logic [WIDTH-1:0] bMag;
  logic [WIDTH-1:0] stepRem;
  logic             stepBit;
  logic [WIDTH-1:0] quoNext;

  assign accept = (state_q == IDLE) & start_i & ~annul_i;
  assign aMag   = (signed_div_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign bMag   = (signed_div_i & b_i[WIDTH-1]) ? -b_i : b_i;

  // quo_q doubles as the dividend shift register: its MSB feeds the step while the
  // new quotient bit enters at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i        (rem_q),
    .dividendBit_i(quo_q[WIDTH-1]),
    .divisor_i    (dvs_q),
    .rem_o        (stepRem),
    .quotBit_o    (stepBit)
  );

  assign quoNext = {quo_q[WIDTH-2:0], stepBit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      negQuot_q <= negQuot_d;
      negRem_q  <= negRem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    negQuot_d = negQuot_q;
    negRem_d  = negRem_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dvs_d     = bMag;
          quo_d     = aMag;
          rem_d     = '0;
          cnt_d     = '0;
          negQuot_d = signed_div_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          negRem_d  = signed_div_i & a_i[WIDTH-1];
          // Divide by zero skips iteration and returns the raw dividend in HI.
          if (b_i == '0) begin
            state_d = DONE;
            hi_d    = a_i;
            lo_d    = '1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (annul_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = stepRem;
          quo_d = quoNext;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            cnt_d   = '0;
            lo_d    = negQuot_q ? -quoNext : quoNext;
            hi_d    = negRem_q ? -stepRem : stepRem;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = ~rst & (accept | (state_q == CALC));
  assign done_o = (state_q == DONE) & ~annul_i;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a reference model queues expected HI/LO per divide,
// a monitor pops and compares on every done pulse, and cycle timing is checked per divide.
module tb_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signedDiv;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  exp_t sbQ[$];
  int   checkCount = 0;
  int   errorCount = 0;
  int   pushCount  = 0;
  int   doneSeen   = 0;
  int   strayDone  = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .signed_div_i(signedDiv),
    .annul_i     (annul),
    .a_i         (a),
    .b_i         (b),
    .busy_o      (busy),
    .done_o      (done),
    .hi_o        (hi),
    .lo_o        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic sgn);
    exp_t   e;
    longint sa, sb, lq, lr;
    if (bv == 32'd0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = av;
    end else begin
      if (sgn) begin
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
      end else begin
        sa = {32'd0, av};
        sb = {32'd0, bv};
      end
      lq   = sa / sb;
      lr   = sa % sb;
      e.lo = lq[31:0];
      e.hi = lr[31:0];
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      doneSeen++;
      if (sbQ.size() == 0) begin
        strayDone++;
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("lo", lo, e.lo);
        checkOutput("hi", hi, e.hi);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge leaving DONE.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sgn,
                               input bit holdStart);
    int doneCycle;
    int busyCycles;
    int doneAt;
    doneCycle  = (bv == 32'd0) ? 1 : 33;
    busyCycles = 0;
    doneAt     = -1;
    start      = 1'b1;
    a          = av;
    b          = bv;
    signedDiv  = sgn;
    sbQ.push_back(model(av, bv, sgn));
    pushCount++;
    for (int n = 0; n <= doneCycle; n++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (done && doneAt < 0) doneAt = n;
      @(posedge clk);
      #1;
      if (!holdStart) start = 1'b0;
    end
    start = 1'b0;
    checkOutput("busyCycles", busyCycles, doneCycle);
    checkOutput("doneCycle", doneAt, doneCycle);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    signedDiv = 1'b0;
    annul     = 1'b0;
    a         = 32'd100;
    b         = 32'd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstHi", hi, 0);
    checkOutput("rstLo", lo, 0);
    start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0);
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(32'h0000_1234, 32'd0, 1'b0, 1'b0);
    applyStimulus(32'h8000_0005, 32'd0, 1'b1, 1'b0);
    applyStimulus(32'd100, 32'd7, 1'b0, 1'b0);

    // Annul at cycle 10 abandons the divide and keeps the previous result.
    start     = 1'b1;
    a         = 32'd50;
    b         = 32'd3;
    signedDiv = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    checkOutput("annulBusy", busy, 0);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("annulHi", hi, 32'd2);
    checkOutput("annulLo", lo, 32'd14);

    applyStimulus(32'd50, 32'd3, 1'b0, 1'b0);
    applyStimulus(32'd77, 32'd5, 1'b0, 1'b1);
    repeat (40) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of CALC.
    start = 1'b1;
    a     = 32'd1000;
    b     = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("midRstBusy", busy, 0);
    checkOutput("midRstHi", hi, 0);
    checkOutput("midRstLo", lo, 0);
    checkOutput("midRstDone", done, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstBusy", busy, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (rb == 32'd0) rb = 32'd1;
      applyStimulus(ra, rb, i[0], 1'b0);
    end

    repeat (5) @(posedge clk);
    checkOutput("strayDone", strayDone, 0);
    checkOutput("doneTotal", doneSeen, pushCount);
    checkOutput("queueEmpty", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the EX stage. It executes DIV/DIVU with a radix-2 restoring algorithm, one quotient bit per cycle, and produces the quotient and remainder written to the LO/HI registers. While it works it raises a stall request to the hazard unit. It is driven by the controller's EX-stage divide controls (divide-request and signed-divide), and its results travel down the pipeline alongside the instruction's HI/LO write enables.

## Interface
- WIDTH, 32, operand width; every width and count below scales with it.

- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  divide requested by the instruction in EX; the controller's divide-request signal.
- signed_div  in  1  1 selects DIV, 0 selects DIVU; sampled with start.
- annul  in  1  EX instruction is flushed; abandons any divide in progress.
- a  in  WIDTH  dividend (rs value after forwarding).
- b  in  WIDTH  divisor (rt value after forwarding).
- busy  out  1  stall request to the hazard unit.
- done  out  1  one-cycle pulse; hi and lo hold a new result.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE:**
  - Latch operands when start=1, annul=0 and rst=0.
  - When signed_div=1, latch |a| and |b| as magnitudes. Also latch neg_q = a[MSB]^b[MSB] and neg_r = a[MSB].
  - Clear the partial remainder and the iteration counter.
  - If b==0, go to DONE. Otherwise go to CALC.
- **CALC:**
  - Each cycle: shift the remainder left by one and bring in the next dividend bit.
  - Subtract the divisor magnitude. If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore the remainder and set the quotient bit to 0.
  - Counter runs 0..WIDTH-1. At WIDTH-1, go to DONE.
- **DONE:**
  - Assert done.
  - hi and lo were loaded on the edge that entered DONE.
  - Return to IDLE on the next edge.
- **Sign fix-up** (signed only, applied on entry to DONE): lo = neg_q ? -q : q; hi = neg_r ? -r : r.
- **Overflow:** 0x80000000 / 0xFFFFFFFF (signed) yields lo=0x80000000, hi=0. No special case is needed; this falls out of the fix-up.
- **Divide by zero:** lo = all ones, hi = a unchanged, for both signed and unsigned.
- **start outside IDLE:** ignored in CALC and in DONE. The same instruction is still in EX during DONE, so it must not retrigger.
- **annul:**
  - In CALC or DONE: next state is IDLE, no done pulse, hi/lo keep their previous values.
  - In IDLE together with start: the start is suppressed.
- **hi/lo:** change only on entry to DONE; otherwise they hold.

## Timing
- **Reset values:** state=IDLE, counter=0, hi=0, lo=0, done=0. busy is forced to 0 while rst=1.
- **busy** = (IDLE & start & ~annul) | CALC. It is combinational so the stall applies in the same cycle the divide reaches EX.
- **Normal divide, start at cycle 0:**
  - CALC during cycles 1..WIDTH.
  - DONE at cycle WIDTH+1 (33), with busy=0 and the results valid.
  - busy is high for WIDTH+1 cycles (0..32).
- **Divide by zero:** busy high in cycle 0 only; DONE at cycle 1.
- **Back-to-back divides:** the earliest next start is accepted in the cycle after DONE.
- **Reset mid-operation:** returns everything to its reset values immediately; no done pulse.

## Structure
- **Shared pipeline package:** state encoding localparams (IDLE/CALC/DONE) and the default WIDTH.
- **div_step:** one combinational sub-module computing {next remainder, quotient bit} from {remainder, dividend bit, divisor}. The FSM, counter, magnitude/sign logic and result registers stay in div_unit.

## Test plan
- **Unsigned:** start at cycle 0, a=100, b=7, signed_div=0 -> busy high cycles 0-32; done at cycle 33 with lo=14, hi=2.
- **Signed:** a=0xFFFFFFF9 (-7), b=2, signed_div=1 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- **Overflow and maximum unsigned:**
  - Signed a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
  - Unsigned a=0xFFFFFFFF, b=0xFFFFFFFF -> lo=1, hi=0.
- **Divide by zero:** a=0x1234, b=0 -> done at cycle 1, lo=0xFFFFFFFF, hi=0x1234; busy high only in cycle 0.
- **Annul:** after a completed 100/7, start 50/3 and assert annul at cycle 10 -> IDLE at cycle 11, no done, hi=2 and lo=14 retained. Then start 50/3 again -> lo=16, hi=2.
- **Reset and start outside IDLE:**
  - Assert rst asynchronously mid-CALC -> hi=lo=0 and busy=0 at once, state IDLE.
  - Hold start high through CALC and DONE -> exactly one done pulse.
